// File: rtl/synth_pkg.sv
// Shared types and constants for the tone-generator output chain.
// Holds the frame-sequencer state encoding and the DAC frame layout.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_e;

    localparam int FRAME_BITS = 16;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    // DAC121S101 frame: two don't-care zeros, power-down bits, then the level.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [1:0]  pd,
                                                         input logic [11:0] level);
        return {2'b00, pd, level};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate strobe: one-cycle tick every SAMPLE_DIV clocks while enabled.
// Disabling parks the counter at zero so re-enabling restarts a full period.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 2272
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises tone-generator samples into 16-bit SPI frames for a 12-bit voltage DAC.
// Every output is driven straight from a flop so the pins never glitch.
module dac_spi_tx
    import synth_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 2272,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [1:0]        pd_mode,
    output logic              dac_sync_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic                  tick;
    logic [FRAME_BITS-1:0] frameWord;

    state_e                state_q, state_d;
    logic [HW-1:0]         halfCnt_q, halfCnt_d;
    logic [4:0]            edgeCnt_q, edgeCnt_d;
    logic [FRAME_BITS-1:0] shiftReg_q, shiftReg_d;
    logic                  syncN_q, syncN_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  frameDone_q, frameDone_d;
    logic                  overrun_q, overrun_d;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (tick)
    );

    assign frameWord = make_frame(pd_mode, sample_in);

    always_comb begin
        state_d     = state_q;
        halfCnt_d   = halfCnt_q;
        edgeCnt_d   = edgeCnt_q;
        shiftReg_d  = shiftReg_q;
        syncN_d     = syncN_q;
        sclk_d      = sclk_q;
        din_d       = din_q;
        busy_d      = busy_q;
        frameDone_d = 1'b0;
        // A tick that lands mid-frame is dropped but remembered until reset.
        overrun_d   = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                syncN_d = 1'b1;
                sclk_d  = 1'b1;
                din_d   = 1'b0;
                busy_d  = 1'b0;
                if (tick) begin
                    state_d    = SHIFT;
                    shiftReg_d = frameWord;
                    din_d      = frameWord[FRAME_BITS-1];
                    syncN_d    = 1'b0;
                    busy_d     = 1'b1;
                    halfCnt_d  = '0;
                    edgeCnt_d  = '0;
                end
            end

            SHIFT: begin
                if (halfCnt_q == HALF_LAST) begin
                    halfCnt_d = '0;
                    edgeCnt_d = edgeCnt_q + 5'd1;
                    // Even edges fall (DAC samples here); odd edges rise and advance data.
                    if (!edgeCnt_q[0]) begin
                        sclk_d = 1'b0;
                    end else if (edgeCnt_q == 5'd31) begin
                        sclk_d  = 1'b1;
                        syncN_d = 1'b1;
                        din_d   = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d     = 1'b1;
                        shiftReg_d = {shiftReg_q[FRAME_BITS-2:0], 1'b0};
                        din_d      = shiftReg_q[FRAME_BITS-2];
                    end
                end else begin
                    halfCnt_d = halfCnt_q + HW'(1);
                end
            end

            GAP: begin
                if (halfCnt_q == HALF_LAST) begin
                    halfCnt_d   = '0;
                    state_d     = IDLE;
                    frameDone_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    halfCnt_d = halfCnt_q + HW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                syncN_d = 1'b1;
                sclk_d  = 1'b1;
                din_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            halfCnt_q   <= '0;
            edgeCnt_q   <= '0;
            shiftReg_q  <= '0;
            syncN_q     <= 1'b1;
            sclk_q      <= 1'b1;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            halfCnt_q   <= halfCnt_d;
            edgeCnt_q   <= edgeCnt_d;
            shiftReg_q  <= shiftReg_d;
            syncN_q     <= syncN_d;
            sclk_q      <= sclk_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dac_sync_n = syncN_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = frameDone_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three instances cover nominal timing,
// an overrunning sample rate and the tightest back-to-back configuration.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic rstA_n = 1'b1, enA = 1'b0;
    logic rstB_n = 1'b1, enB = 1'b0;
    logic rstC_n = 1'b1, enC = 1'b0;
    logic [11:0] sampleA = '0, sampleB = '0, sampleC = '0;
    logic [1:0]  pdA = '0, pdB = '0, pdC = '0;
    logic syncA, sclkA, dinA, busyA, doneA, ovA;
    logic syncB, sclkB, dinB, busyB, doneB, ovB;
    logic syncC, sclkC, dinC, busyC, doneC, ovC;

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(80), .DATA_W(12)) dutA (
        .clk(clk), .rst_n(rstA_n), .enable(enA), .sample_in(sampleA), .pd_mode(pdA),
        .dac_sync_n(syncA), .dac_sclk(sclkA), .dac_din(dinA),
        .busy(busyA), .frame_done(doneA), .overrun(ovA)
    );

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(40), .DATA_W(12)) dutB (
        .clk(clk), .rst_n(rstB_n), .enable(enB), .sample_in(sampleB), .pd_mode(pdB),
        .dac_sync_n(syncB), .dac_sclk(sclkB), .dac_din(dinB),
        .busy(busyB), .frame_done(doneB), .overrun(ovB)
    );

    dac_spi_tx #(.CLK_DIV(1), .SAMPLE_DIV(34), .DATA_W(12)) dutC (
        .clk(clk), .rst_n(rstC_n), .enable(enC), .sample_in(sampleC), .pd_mode(pdC),
        .dac_sync_n(syncC), .dac_sclk(sclkC), .dac_din(dinC),
        .busy(busyC), .frame_done(doneC), .overrun(ovC)
    );

    // Selects which instance the shared frame-capture tasks watch.
    int sel = 0;
    logic monSync, monSclk, monDin, monDone;
    always_comb begin
        monSync = syncA; monSclk = sclkA; monDin = dinA; monDone = doneA;
        case (sel)
            1: begin monSync = syncB; monSclk = sclkB; monDin = dinB; monDone = doneB; end
            2: begin monSync = syncC; monSclk = sclkC; monDin = dinC; monDone = doneC; end
            default: ;
        endcase
    end

    task automatic waitFrameStart(input int limit, output int t0, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (monSync !== 1'b1 && n < limit) begin
            @(posedge clk); #1; n++;
        end
        while (n < limit) begin
            @(posedge clk); #1; n++;
            if (monSync === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        t0 = cyc;
    endtask

    // Called at the first sync-low sample; records bits on every SCLK fall.
    task automatic captureFrame(input int dropAt, output logic [15:0] word,
                                output int syncLow, output int doneAt, output int falls);
        logic prevSclk;
        word = '0; syncLow = 1; doneAt = -1; falls = 0;
        prevSclk = monSclk;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk); #1;
            if (i == dropAt) begin
                case (sel)
                    0: enA = 1'b0;
                    1: enB = 1'b0;
                    default: enC = 1'b0;
                endcase
            end
            if (monSync === 1'b0) syncLow++;
            if (prevSclk === 1'b1 && monSclk === 1'b0) begin
                falls++;
                word = {word[14:0], monDin};
            end
            prevSclk = monSclk;
            if (monDone === 1'b1) begin
                doneAt = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
        #1;
        vectors++; if (syncA !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_sync_n: got %b want 1", syncA); end
        vectors++; if (sclkA !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_sclk: got %b want 1", sclkA); end
        vectors++; if (dinA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_din: got %b want 0", dinA); end
        vectors++; if (busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
        vectors++; if (doneA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b want 0", doneA); end
        vectors++; if (ovA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b want 0", ovA); end
    endtask

    task automatic test_full_scale();
        int r, t0, t1, syncLow, doneAt, falls;
        bit ok;
        logic [15:0] word;
        sel = 0; sampleA = 12'hFFF; pdA = 2'b00; enA = 1'b1;
        @(posedge clk); #1;
        rstA_n = 1'b1;
        r = cyc;
        waitFrameStart(200, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL fs_start_timeout: got none want sync_n fall"); end
        vectors++; if (t0 - r !== 80) begin miscompares++; $display("[TB] FAIL fs_first_tick: got %0d want 80", t0 - r); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h0FFF) begin miscompares++; $display("[TB] FAIL fs_word: got %h want 0fff", word); end
        vectors++; if (syncLow !== 64) begin miscompares++; $display("[TB] FAIL fs_sync_low: got %0d want 64", syncLow); end
        vectors++; if (doneAt !== 66) begin miscompares++; $display("[TB] FAIL fs_frame_done: got %0d want 66", doneAt); end
        vectors++; if (falls !== 16) begin miscompares++; $display("[TB] FAIL fs_falls: got %0d want 16", falls); end
        waitFrameStart(200, t1, ok);
        vectors++; if (!ok || (t1 - t0) !== 80) begin miscompares++; $display("[TB] FAIL fs_period: got %0d want 80", t1 - t0); end
    endtask

    task automatic test_latch();
        int t0, syncLow, doneAt, falls;
        bit ok;
        logic [15:0] word;
        sel = 0; sampleA = 12'hA5C; pdA = 2'b11;
        waitFrameStart(200, t0, ok);
        sampleA = 12'h000; pdA = 2'b00;
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL latch_start_timeout: got none want sync_n fall"); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h3A5C) begin miscompares++; $display("[TB] FAIL latch_word: got %h want 3a5c", word); end
        vectors++; if (falls !== 16) begin miscompares++; $display("[TB] FAIL latch_falls: got %0d want 16", falls); end
        vectors++; if (doneAt !== 66) begin miscompares++; $display("[TB] FAIL latch_frame_done: got %0d want 66", doneAt); end
    endtask

    task automatic test_reset_mid_frame();
        int t0, n, falls;
        bit ok;
        logic prevSclk;
        sel = 0; sampleA = 12'h3C3; pdA = 2'b01;
        waitFrameStart(200, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_start_timeout: got none want sync_n fall"); end
        falls = 0; n = 0; prevSclk = sclkA;
        while (falls < 8 && n < 100) begin
            @(posedge clk); #1; n++;
            if (prevSclk === 1'b1 && sclkA === 1'b0) falls++;
            prevSclk = sclkA;
        end
        vectors++; if (falls !== 8) begin miscompares++; $display("[TB] FAIL mid_eighth_fall: got %0d want 8", falls); end
        rstA_n = 1'b0;
        #1;
        vectors++; if (syncA !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_sync_n: got %b want 1", syncA); end
        vectors++; if (sclkA !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_sclk: got %b want 1", sclkA); end
        vectors++; if (dinA !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_din: got %b want 0", dinA); end
        vectors++; if (busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b want 0", busyA); end
        repeat (3) @(posedge clk);
        #1;
        rstA_n = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (syncA === 1'b0) break;
        end
        vectors++; if (n !== 80) begin miscompares++; $display("[TB] FAIL mid_first_tick: got %0d want 80", n); end
        vectors++; if (ovA !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_overrun: got %b want 0", ovA); end
    endtask

    task automatic test_enable_drop();
        int t0, syncLow, doneAt, falls, lowCycles, busyCycles;
        bit ok;
        logic [15:0] word;
        sel = 0;
        waitFrameStart(200, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL drop_start_timeout: got none want sync_n fall"); end
        captureFrame(10, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h13C3) begin miscompares++; $display("[TB] FAIL drop_word: got %h want 13c3", word); end
        vectors++; if (falls !== 16) begin miscompares++; $display("[TB] FAIL drop_falls: got %0d want 16", falls); end
        vectors++; if (doneAt !== 66) begin miscompares++; $display("[TB] FAIL drop_frame_done: got %0d want 66", doneAt); end
        lowCycles = 0; busyCycles = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (syncA !== 1'b1) lowCycles++;
            if (busyA !== 1'b0) busyCycles++;
        end
        vectors++; if (lowCycles !== 0) begin miscompares++; $display("[TB] FAIL drop_quiet_sync: got %0d want 0", lowCycles); end
        vectors++; if (busyCycles !== 0) begin miscompares++; $display("[TB] FAIL drop_quiet_busy: got %0d want 0", busyCycles); end
    endtask

    task automatic test_overrun();
        int t0, syncLow, doneAt, falls;
        bit ok;
        logic [15:0] word;
        sel = 1; sampleB = 12'h555; pdB = 2'b10; enB = 1'b1;
        @(posedge clk); #1;
        rstB_n = 1'b1;
        waitFrameStart(100, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ovr_start_timeout: got none want sync_n fall"); end
        vectors++; if (ovB !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_initial: got %b want 0", ovB); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h2555) begin miscompares++; $display("[TB] FAIL ovr_word1: got %h want 2555", word); end
        vectors++; if (falls !== 16 || doneAt !== 66) begin miscompares++; $display("[TB] FAIL ovr_frame1: got falls=%0d done=%0d want 16/66", falls, doneAt); end
        vectors++; if (ovB !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_set: got %b want 1", ovB); end
        waitFrameStart(100, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ovr_restart_timeout: got none want sync_n fall"); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h2555 || falls !== 16 || doneAt !== 66) begin miscompares++; $display("[TB] FAIL ovr_frame2: got %h/%0d/%0d want 2555/16/66", word, falls, doneAt); end
        repeat (50) @(posedge clk);
        #1;
        vectors++; if (ovB !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_sticky: got %b want 1", ovB); end
        rstB_n = 1'b0;
        #1;
        vectors++; if (ovB !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_cleared: got %b want 0", ovB); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, syncLow, doneAt, falls;
        bit ok;
        logic [15:0] word;
        sel = 2; sampleC = 12'h0F0; pdC = 2'b00; enC = 1'b1;
        @(posedge clk); #1;
        rstC_n = 1'b1;
        waitFrameStart(100, t0, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_start_timeout: got none want sync_n fall"); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h00F0) begin miscompares++; $display("[TB] FAIL b2b_word: got %h want 00f0", word); end
        vectors++; if (syncLow !== 32) begin miscompares++; $display("[TB] FAIL b2b_sync_low: got %0d want 32", syncLow); end
        vectors++; if (doneAt !== 33 || falls !== 16) begin miscompares++; $display("[TB] FAIL b2b_frame: got done=%0d falls=%0d want 33/16", doneAt, falls); end
        waitFrameStart(10, t1, ok);
        vectors++; if (!ok || (t1 - t0) !== 34) begin miscompares++; $display("[TB] FAIL b2b_period: got %0d want 34", t1 - t0); end
        captureFrame(-1, word, syncLow, doneAt, falls);
        vectors++; if (word !== 16'h00F0 || doneAt !== 33) begin miscompares++; $display("[TB] FAIL b2b_frame2: got %h/%0d want 00f0/33", word, doneAt); end
        vectors++; if (ovC !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun: got %b want 0", ovC); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_latch();
        test_reset_mid_frame();
        test_enable_drop();
        test_overrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
